mfi_iic_req_ctrl: RTL and testbench

MFI_IIC_REQ_CTRL -- requirements
Module: mfi_iic_req_ctrl

---
 rtl/mfi_iic_req_ctrl_if.sv | 46 ++++
 rtl/mfi_iic_req_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mfi_iic_req_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mfi_iic_req_ctrl_if.sv
// Request/bus bundle for mfi_iic_req_ctrl.
// The names keep the i_/o_ direction prefixes as seen from the controller.
// Signal groups:
//   boot gate   : i_boot_pass
//   request     : i_req_valid, o_req_ready, i_req_rd, i_req_reg, i_req_len
//   guard delay : o_iic_start, i_iic_dly_done, o_iic_ack
//   I2C master  : o_i2c_go, o_i2c_addr/rd/reg/len, i_i2c_busy, i_i2c_nack
//   status      : o_done, o_err, o_retry_cnt
// Modports:
//   slave  : the controller's view.
//   master : the view of the environment that drives the controller.
interface mfi_iic_req_ctrl_if;
  logic       i_boot_pass;
  logic       i_req_valid;
  logic       o_req_ready;
  logic       i_req_rd;
  logic [7:0] i_req_reg;
  logic [7:0] i_req_len;
  logic       o_iic_start;
  logic       i_iic_dly_done;
  logic       o_iic_ack;
  logic       o_i2c_go;
  logic [6:0] o_i2c_addr;
  logic       o_i2c_rd;
  logic [7:0] o_i2c_reg;
  logic [7:0] o_i2c_len;
  logic       i_i2c_busy;
  logic       i_i2c_nack;
  logic       o_done;
  logic       o_err;
  logic [1:0] o_retry_cnt;

  modport slave (
    input  i_boot_pass, i_req_valid, i_req_rd, i_req_reg, i_req_len,
           i_iic_dly_done, i_i2c_busy, i_i2c_nack,
    output o_req_ready, o_iic_start, o_iic_ack, o_i2c_go, o_i2c_addr,
           o_i2c_rd, o_i2c_reg, o_i2c_len, o_done, o_err, o_retry_cnt
  );

  modport master (
    output i_boot_pass, i_req_valid, i_req_rd, i_req_reg, i_req_len,
           i_iic_dly_done, i_i2c_busy, i_i2c_nack,
    input  o_req_ready, o_iic_start, o_iic_ack, o_i2c_go, o_i2c_addr,
           o_i2c_rd, o_i2c_reg, o_i2c_len, o_done, o_err, o_retry_cnt
  );
endinterface

// File: rtl/mfi_iic_req_ctrl.sv
// Request controller for the MFi authentication coprocessor on I2C.
// Behaviour:
//   - Accepts one register read/write request at a time, but only after boot.
//   - Brackets each I2C attempt with the inter-transaction guard delay.
//   - Launches the attempt and retries it on NACK.
//   - Reports completion with a single o_done or o_err pulse.
// Ports:
//   i_clk   : clock; all logic is rising-edge.
//   i_rst_n : asynchronous active-low reset.
//   bus     : mfi_iic_req_ctrl_if.slave (request, guard delay, I2C, status).
// Build option:
//   MFI_IIC_RETRY_EN defined   : a NACK re-launches, up to RETRY_MAX times.
//   MFI_IIC_RETRY_EN undefined : any NACK ends in o_err; o_retry_cnt stays 0.
// All outputs are registered.
module mfi_iic_req_ctrl #(
  parameter logic [6:0]  DEV_ADDR  = 7'h10,
  parameter int unsigned RETRY_MAX = 3,
  parameter int unsigned BUSY_TO   = 1024
) (
  input logic                i_clk,
  input logic                i_rst_n,
  mfi_iic_req_ctrl_if.slave  bus
);

  localparam int unsigned TO_W = 11;
  localparam int unsigned RC_W = 2;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TO - 1);
`ifdef MFI_IIC_RETRY_EN
  localparam logic [RC_W-1:0] RC_MAX = RC_W'(RETRY_MAX);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_GUARD,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_XFER,
    S_CHECK,
    S_ACK
  } state_e;

  state_e          state_q, state_d;
  logic            ready_q, ready_d;
  logic            start_q, start_d;
  logic            ack_q, ack_d;
  logic            go_q, go_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [6:0]      addr_q, addr_d;
  logic            rd_q, rd_d;
  logic [7:0]      reg_q, reg_d;
  logic [7:0]      len_q, len_d;
  logic [RC_W-1:0] retry_q, retry_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            busy_q, busy_d;
  logic            nack_q, nack_d;

  // Next-state and output decode
  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    ack_d    = 1'b0;
    go_d     = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    addr_d   = addr_q;
    rd_d     = rd_q;
    reg_d    = reg_q;
    len_d    = len_q;
    retry_d  = retry_q;
    to_cnt_d = to_cnt_q;
    busy_d   = bus.i_i2c_busy;
    nack_d   = nack_q;

    // Losing boot_pass mid-request ends it with an error and no further launch.
    // ACK is excluded so the request still gets exactly one completion pulse.
    if (!bus.i_boot_pass && state_q != S_IDLE && state_q != S_ACK) begin
      err_d   = 1'b1;
      state_d = S_ACK;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.i_req_valid && ready_q) begin
            addr_d  = DEV_ADDR;
            rd_d    = bus.i_req_rd;
            reg_d   = bus.i_req_reg;
            len_d   = bus.i_req_len;
            retry_d = '0;
            start_d = 1'b1;
            state_d = S_GUARD;
          end
        end
        S_GUARD: begin
          if (bus.i_iic_dly_done) state_d = S_LAUNCH;
        end
        S_LAUNCH: begin
          go_d     = 1'b1;
          to_cnt_d = '0;
          state_d  = S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (bus.i_i2c_busy) begin
            state_d = S_XFER;
          end else if (to_cnt_q == TO_LAST) begin
            err_d   = 1'b1;
            state_d = S_ACK;
          end else if (to_cnt_q != {TO_W{1'b1}}) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        S_XFER: begin
          // NACK is only meaningful on the busy falling edge.
          if (busy_q && !bus.i_i2c_busy) begin
            nack_d  = bus.i_i2c_nack;
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (!nack_q) begin
            done_d  = 1'b1;
            state_d = S_ACK;
          end
`ifdef MFI_IIC_RETRY_EN
          else if (retry_q < RC_MAX) begin
            retry_d = retry_q + RC_W'(1);
            start_d = 1'b1;
            state_d = S_GUARD;
          end
`endif
          else begin
            err_d   = 1'b1;
            state_d = S_ACK;
          end
        end
        S_ACK: begin
          ack_d   = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    ready_d = (state_d == S_IDLE) && bus.i_boot_pass;
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      start_q  <= 1'b0;
      ack_q    <= 1'b0;
      go_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      reg_q    <= '0;
      len_q    <= '0;
      retry_q  <= '0;
      to_cnt_q <= '0;
      busy_q   <= 1'b0;
      nack_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      start_q  <= start_d;
      ack_q    <= ack_d;
      go_q     <= go_d;
      done_q   <= done_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      reg_q    <= reg_d;
      len_q    <= len_d;
      retry_q  <= retry_d;
      to_cnt_q <= to_cnt_d;
      busy_q   <= busy_d;
      nack_q   <= nack_d;
    end
  end

  assign bus.o_req_ready = ready_q;
  assign bus.o_iic_start = start_q;
  assign bus.o_iic_ack   = ack_q;
  assign bus.o_i2c_go    = go_q;
  assign bus.o_i2c_addr  = addr_q;
  assign bus.o_i2c_rd    = rd_q;
  assign bus.o_i2c_reg   = reg_q;
  assign bus.o_i2c_len   = len_q;
  assign bus.o_done      = done_q;
  assign bus.o_err       = err_q;
  assign bus.o_retry_cnt = retry_q;

endmodule

// File: tb/tb_mfi_iic_req_ctrl.sv
// Directed bench for mfi_iic_req_ctrl.
// Simple models stand in for the guard-delay timer and the I2C master.
module tb_mfi_iic_req_ctrl;

`ifdef MFI_IIC_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mfi_iic_req_ctrl_if bus();

  mfi_iic_req_ctrl dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int go_cnt = 0, start_cnt = 0, ack_cnt = 0, done_cnt = 0, err_cnt = 0;
  int both_cnt = 0;
  int go_cyc = 0, err_cyc = 0, ack_cyc = 0;
  logic [7:0] nack_bits = 8'h00;
  int attempt = 0;
  bit no_busy = 1'b0;
  int busy_len = 50;
  int dly_cnt = 0;
  logic nk_cur;

  // Pulse monitor, sampled just after the active edge
  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.o_i2c_go)    begin go_cnt++;  go_cyc  = cyc; end
    if (bus.o_iic_start) start_cnt++;
    if (bus.o_iic_ack)   begin ack_cnt++; ack_cyc = cyc; end
    if (bus.o_done)      done_cnt++;
    if (bus.o_err)       begin err_cnt++; err_cyc = cyc; end
    if (bus.o_done && bus.o_err) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    go_cnt = 0; start_cnt = 0; ack_cnt = 0; done_cnt = 0; err_cnt = 0;
    attempt = 0;
  endtask

  task automatic send(input logic rd, input logic [7:0] rg, input logic [7:0] ln);
    bus.i_req_rd    = rd;
    bus.i_req_reg   = rg;
    bus.i_req_len   = ln;
    bus.i_req_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (bus.o_req_ready) begin
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bus.i_req_valid = 1'b0;
  endtask

  task automatic wait_end();
    for (int k = 0; k < 6000; k++) begin
      if (done_cnt + err_cnt != 0) break;
      @(negedge clk);
    end
  endtask

  task automatic wait_busy(input logic lvl);
    for (int k = 0; k < 500; k++) begin
      if (bus.i_i2c_busy == lvl) break;
      @(negedge clk);
    end
  endtask

  // Guard-delay timer: done 10 cycles after start, cleared by start or ack
  initial begin
    bus.i_iic_dly_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.o_iic_start) begin
        bus.i_iic_dly_done = 1'b0;
        dly_cnt = 10;
      end else if (dly_cnt > 0) begin
        dly_cnt--;
        if (dly_cnt == 0) bus.i_iic_dly_done = 1'b1;
      end
      if (bus.o_iic_ack) bus.i_iic_dly_done = 1'b0;
    end
  end

  // I2C master: busy for busy_len cycles, NACK per attempt from nack_bits
  initial begin
    bus.i_i2c_busy = 1'b0;
    bus.i_i2c_nack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.o_i2c_go && !no_busy) begin
        nk_cur = (attempt < 8) ? nack_bits[attempt] : 1'b1;
        attempt++;
        repeat (2) @(negedge clk);
        bus.i_i2c_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        bus.i_i2c_busy = 1'b0;
        bus.i_i2c_nack = nk_cur;
        @(negedge clk);
        bus.i_i2c_nack = 1'b0;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.i_boot_pass = 1'b1;
    bus.i_req_valid = 1'b0;
    bus.i_req_rd    = 1'b0;
    bus.i_req_reg   = 8'h00;
    bus.i_req_len   = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.o_req_ready), 32'd0);
    chk("rst_outs", 32'({bus.o_iic_start, bus.o_iic_ack, bus.o_i2c_go, bus.o_done, bus.o_err}), 32'd0);
    chk("rst_desc", 32'({bus.o_i2c_addr, bus.o_i2c_rd, bus.o_i2c_reg, bus.o_i2c_len, bus.o_retry_cnt}), 32'd0);

    // Boot gating, then clean read
    bus.i_boot_pass = 1'b0;
    rst_n = 1'b1;
    clr();
    bus.i_req_rd = 1'b1; bus.i_req_reg = 8'h30; bus.i_req_len = 8'd2;
    bus.i_req_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("gate_ready", 32'(bus.o_req_ready), 32'd0);
    chk("gate_start", 32'(start_cnt), 32'd0);
    bus.i_boot_pass = 1'b1;
    @(negedge clk);
    chk("boot_ready", 32'(bus.o_req_ready), 32'd1);
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    chk("boot_accept", 32'(bus.o_iic_start), 32'd1);
    wait_end();
    chk("rd_done", 32'(done_cnt), 32'd1);
    chk("rd_err", 32'(err_cnt), 32'd0);
    chk("rd_go", 32'(go_cnt), 32'd1);
    chk("rd_desc", 32'({bus.o_i2c_addr, bus.o_i2c_rd, bus.o_i2c_reg, bus.o_i2c_len}), 32'({7'h10, 1'b1, 8'h30, 8'd2}));
    chk("rd_retry", 32'(bus.o_retry_cnt), 32'd0);
    @(negedge clk);
    chk("rd_ack", 32'(bus.o_iic_ack), 32'd1);
    @(negedge clk);
    chk("rd_ready_back", 32'(bus.o_req_ready), 32'd1);

    // NACK, NACK, ACK
    clr();
    nack_bits = 8'b0000_0011;
    send(1'b0, 8'h31, 8'd4);
    wait_end();
    repeat (3) @(negedge clk);
    chk("rty_go", 32'(go_cnt), RETRY_EN ? 32'd3 : 32'd1);
    chk("rty_start", 32'(start_cnt), RETRY_EN ? 32'd3 : 32'd1);
    chk("rty_cnt", 32'(bus.o_retry_cnt), RETRY_EN ? 32'd2 : 32'd0);
    chk("rty_done", 32'(done_cnt), RETRY_EN ? 32'd1 : 32'd0);
    chk("rty_err", 32'(err_cnt), RETRY_EN ? 32'd0 : 32'd1);
    chk("rty_desc", 32'({bus.o_i2c_rd, bus.o_i2c_reg, bus.o_i2c_len}), 32'({1'b0, 8'h31, 8'd4}));

    // NACK on every attempt
    clr();
    nack_bits = 8'hFF;
    send(1'b1, 8'h00, 8'd128);
    wait_end();
    repeat (3) @(negedge clk);
    chk("exh_go", 32'(go_cnt), RETRY_EN ? 32'd4 : 32'd1);
    chk("exh_start", 32'(start_cnt), RETRY_EN ? 32'd4 : 32'd1);
    chk("exh_cnt", 32'(bus.o_retry_cnt), RETRY_EN ? 32'd3 : 32'd0);
    chk("exh_err", 32'(err_cnt), 32'd1);
    chk("exh_done", 32'(done_cnt), 32'd0);
    chk("exh_ack", 32'(ack_cnt), 32'd1);

    // Busy never rises
    clr();
    nack_bits = 8'h00;
    no_busy = 1'b1;
    send(1'b1, 8'h02, 8'd1);
    wait_end();
    chk("to_retry_clr", 32'(bus.o_retry_cnt), 32'd0);
    repeat (2) @(negedge clk);
    chk("to_err", 32'(err_cnt), 32'd1);
    chk("to_done", 32'(done_cnt), 32'd0);
    chk("to_latency", 32'(err_cyc - go_cyc), 32'd1024);
    chk("to_ack", 32'(ack_cnt), 32'd1);
    chk("to_ack_lat", 32'(ack_cyc - err_cyc), 32'd1);
    no_busy = 1'b0;

    // Boot drop during XFER
    clr();
    send(1'b1, 8'h10, 8'd8);
    wait_busy(1'b1);
    repeat (5) @(negedge clk);
    bus.i_boot_pass = 1'b0;
    wait_end();
    repeat (2) @(negedge clk);
    chk("abt_err", 32'(err_cnt), 32'd1);
    chk("abt_done", 32'(done_cnt), 32'd0);
    chk("abt_go", 32'(go_cnt), 32'd1);
    chk("abt_ack", 32'(ack_cnt), 32'd1);
    chk("abt_ready", 32'(bus.o_req_ready), 32'd0);
    bus.i_boot_pass = 1'b1;
    wait_busy(1'b0);
    repeat (3) @(negedge clk);

    // Reset during XFER, then a normal zero-length write
    clr();
    send(1'b1, 8'h5A, 8'd3);
    wait_busy(1'b1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", 32'({bus.o_req_ready, bus.o_iic_start, bus.o_iic_ack, bus.o_i2c_go, bus.o_done, bus.o_err}), 32'd0);
    chk("mid_rst_desc", 32'({bus.o_i2c_addr, bus.o_i2c_rd, bus.o_i2c_reg, bus.o_i2c_len, bus.o_retry_cnt}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(bus.o_req_ready), 32'd1);
    wait_busy(1'b0);
    repeat (3) @(negedge clk);
    clr();
    send(1'b0, 8'hA5, 8'd0);
    wait_end();
    chk("post_done", 32'(done_cnt), 32'd1);
    chk("post_err", 32'(err_cnt), 32'd0);
    chk("post_go", 32'(go_cnt), 32'd1);
    chk("post_desc", 32'({bus.o_i2c_addr, bus.o_i2c_rd, bus.o_i2c_reg, bus.o_i2c_len}), 32'({7'h10, 1'b0, 8'hA5, 8'd0}));
    repeat (3) @(negedge clk);
    chk("no_overlap", 32'(both_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
